// File: rtl/nand_bus_ctrl.sv
// nand_bus_ctrl -- raw 8-bit NAND flash bus sequencer.
//
// Runs one bus cycle per accepted request (command latch, address latch,
// data write or data read) with programmable setup / strobe / hold timing
// counted in clk cycles.  Chip enable stays low across back-to-back
// requests and is released after CE_IDLE idle cycles.
//
// Build option: define NAND_RB_WAIT_EN to make the controller wait for the
// NAND R/B# line after CMD bytes 0x10, 0x30, 0xD0 and 0xFF.  Without it,
// nand_rb is ignored and every op returns straight to IDLE.
//
// Ports:
//   clk, reset            clock; synchronous active-high reset
//   req_valid/req_ready   request handshake (ready only in IDLE)
//   req_op                00 CMD, 01 ADDR, 10 WRITE, 11 READ
//   req_data              byte for CMD/ADDR/WRITE
//   rsp_valid/rsp_data    one-cycle pulse + byte when a READ completes
//   busy                  controller not in IDLE
//   nand_rb               NAND R/B# (low = busy), optional feature only
//   nce/ncle/nale/nwe/nre NAND control pins (nce, nwe, nre active low)
//   nand_oe/dout/din      data pad enable, outgoing and incoming byte
module nand_bus_ctrl #(
    parameter int T_SETUP = 2,
    parameter int T_PULSE = 2,
    parameter int T_HOLD  = 1,
    parameter int CE_IDLE = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req_valid,
    input  logic [1:0] req_op,
    input  logic [7:0] req_data,
    output logic       req_ready,
    output logic       rsp_valid,
    output logic [7:0] rsp_data,
    output logic       busy,
    input  logic       nand_rb,
    output logic       nce,
    output logic       ncle,
    output logic       nale,
    output logic       nwe,
    output logic       nre,
    output logic       nand_oe,
    output logic [7:0] nand_dout,
    input  logic [7:0] nand_din
);

    localparam int CW = 16;
    localparam logic [CW-1:0] SETUP_LAST = CW'(T_SETUP - 1);
    localparam logic [CW-1:0] PULSE_LAST = CW'(T_PULSE - 1);
    localparam logic [CW-1:0] HOLD_LAST  = CW'(T_HOLD - 1);
    localparam logic [CW-1:0] IDLE_LAST  = CW'(CE_IDLE - 1);

    localparam logic [1:0] OP_CMD  = 2'b00;
    localparam logic [1:0] OP_ADDR = 2'b01;
    localparam logic [1:0] OP_READ = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        PULSE,
        HOLD
`ifdef NAND_RB_WAIT_EN
        , WAIT_RB
`endif
    } state_t;

    state_t        state_q, state_d;
    logic [1:0]    op_q, op_d;
    logic [7:0]    data_q, data_d;
    logic [CW-1:0] phase_cnt_q, phase_cnt_d;
    logic [CW-1:0] idle_cnt_q, idle_cnt_d;
    logic          ce_active_q, ce_active_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic [7:0]    rsp_data_q, rsp_data_d;

    logic accept;
    logic in_op;
    logic is_read;

`ifdef NAND_RB_WAIT_EN
    // tWB: fixed delay before R/B# is trusted after a busy-causing command
    localparam logic [CW-1:0] TWB_CYCLES = CW'(4);
    logic rb_meta_q, rb_meta_d;
    logic rb_sync_q, rb_sync_d;
`else
    logic unused_rb;
    assign unused_rb = nand_rb;
`endif

    assign req_ready = (state_q == IDLE) && !reset;
    assign accept    = req_valid && req_ready;
    assign in_op     = (state_q == SETUP) || (state_q == PULSE) || (state_q == HOLD);
    assign is_read   = (op_q == OP_READ);

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        data_d      = data_q;
        phase_cnt_d = phase_cnt_q;
        idle_cnt_d  = idle_cnt_q;
        ce_active_d = ce_active_q;
        rsp_valid_d = 1'b0;
        rsp_data_d  = rsp_data_q;
`ifdef NAND_RB_WAIT_EN
        rb_meta_d   = nand_rb;
        rb_sync_d   = rb_meta_q;
`endif
        case (state_q)
            IDLE: begin
                if (accept) begin
                    op_d        = req_op;
                    data_d      = req_data;
                    phase_cnt_d = '0;
                    idle_cnt_d  = '0;
                    ce_active_d = 1'b1;
                    state_d     = SETUP;
                end else if (ce_active_q) begin
                    // nce is released combinationally once the count hits
                    // IDLE_LAST; drop the flag so it stays released.
                    if (idle_cnt_q >= IDLE_LAST) begin
                        ce_active_d = 1'b0;
                        idle_cnt_d  = '0;
                    end else begin
                        idle_cnt_d = idle_cnt_q + 1'b1;
                    end
                end
            end
            SETUP: begin
                if (phase_cnt_q == SETUP_LAST) begin
                    phase_cnt_d = '0;
                    state_d     = PULSE;
                end else begin
                    phase_cnt_d = phase_cnt_q + 1'b1;
                end
            end
            PULSE: begin
                if (phase_cnt_q == PULSE_LAST) begin
                    // sample while nre is still low, just before it rises
                    if (is_read) begin
                        rsp_data_d = nand_din;
                    end
                    phase_cnt_d = '0;
                    state_d     = HOLD;
                end else begin
                    phase_cnt_d = phase_cnt_q + 1'b1;
                end
            end
            HOLD: begin
                if (phase_cnt_q == HOLD_LAST) begin
                    phase_cnt_d = '0;
                    rsp_valid_d = is_read;
                    state_d     = IDLE;
`ifdef NAND_RB_WAIT_EN
                    if ((op_q == OP_CMD) && (data_q inside {8'h10, 8'h30, 8'hD0, 8'hFF})) begin
                        state_d = WAIT_RB;
                    end
`endif
                end else begin
                    phase_cnt_d = phase_cnt_q + 1'b1;
                end
            end
`ifdef NAND_RB_WAIT_EN
            WAIT_RB: begin
                if (phase_cnt_q != TWB_CYCLES) begin
                    phase_cnt_d = phase_cnt_q + 1'b1;
                end else if (rb_sync_q) begin
                    phase_cnt_d = '0;
                    state_d     = IDLE;
                end
            end
`endif
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            op_q        <= 2'b00;
            data_q      <= 8'h00;
            phase_cnt_q <= '0;
            idle_cnt_q  <= '0;
            ce_active_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= 8'h00;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            data_q      <= data_d;
            phase_cnt_q <= phase_cnt_d;
            idle_cnt_q  <= idle_cnt_d;
            ce_active_q <= ce_active_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

`ifdef NAND_RB_WAIT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            rb_meta_q <= 1'b0;
            rb_sync_q <= 1'b0;
        end else begin
            rb_meta_q <= rb_meta_d;
            rb_sync_q <= rb_sync_d;
        end
    end
`endif

    // Pin outputs decode straight from registered state, so the control
    // lines change only on clock edges.
    assign busy      = (state_q != IDLE);
    assign nce       = !(busy || (ce_active_q && (idle_cnt_q < IDLE_LAST)));
    assign ncle      = in_op && (op_q == OP_CMD);
    assign nale      = in_op && (op_q == OP_ADDR);
    assign nand_oe   = in_op && !is_read;
    assign nand_dout = data_q;
    assign nwe       = !((state_q == PULSE) && !is_read);
    assign nre       = !((state_q == PULSE) && is_read);
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_nand_bus_ctrl.sv
// Self-checking bench for nand_bus_ctrl.  A cycle-level reference model
// (op progress as a cycle offset, idle-cycle tally) predicts every output;
// each scenario task compares all outputs once per cycle.
`timescale 1ns/1ps
module tb_nand_bus_ctrl;

    localparam int TS = 2;
    localparam int TP = 2;
    localparam int TH = 1;
    localparam int CE = 16;
    localparam int N  = TS + TP + TH;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       req_valid = 1'b0;
    logic [1:0] req_op = 2'b00;
    logic [7:0] req_data = 8'h00;
    logic       nand_rb = 1'b1;
    logic [7:0] nand_din = 8'h00;
    logic       req_ready, rsp_valid, busy;
    logic [7:0] rsp_data, nand_dout;
    logic       nce, ncle, nale, nwe, nre, nand_oe;

    always #5 clk = ~clk;

    nand_bus_ctrl #(.T_SETUP(TS), .T_PULSE(TP), .T_HOLD(TH), .CE_IDLE(CE)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_op(req_op), .req_data(req_data), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .busy(busy), .nand_rb(nand_rb),
        .nce(nce), .ncle(ncle), .nale(nale), .nwe(nwe), .nre(nre),
        .nand_oe(nand_oe), .nand_dout(nand_dout), .nand_din(nand_din)
    );

    typedef struct {
        logic [1:0] op;
        logic [7:0] data;
        int         gap;
    } req_t;

    req_t q[$];
    int   gap_left = 0;

    // Reference model state
    int         m_k = 0;        // cycle offset inside current op (0 = not in op)
    int         m_wait = -1;    // cycles spent waiting on R/B# (-1 = not waiting)
    int         m_idle = 0;     // idle cycles elapsed since the last op finished
    bit         m_used = 0;     // an op has been accepted since reset
    bit         m_acc = 0;
    bit         m_rsp_pulse = 0;
    bit         m_rb1 = 0, m_rb2 = 0;
    logic [1:0] m_op = 2'b00;
    logic [7:0] m_data = 8'h00;
    logic [7:0] m_rsp_data = 8'h00;

    int compared = 0;
    int mismatched = 0;
    logic [24:0] e, o, mk;

    // {nce,ncle,nale,nwe,nre,oe,dout[7:0],ready,rsp_valid,rsp_data[7:0],busy}
    function automatic logic [24:0] exp_vec();
        logic e_nce, e_ncle, e_nale, e_nwe, e_nre, e_oe, e_busy;
        logic [7:0] e_dout;
        e_busy = (m_k > 0) || (m_wait >= 0);
        e_nce  = !(e_busy || (m_used && (m_idle + 1 < CE)));
        e_ncle = 1'b0; e_nale = 1'b0; e_nwe = 1'b1; e_nre = 1'b1; e_oe = 1'b0;
        e_dout = m_data;
        if (m_k > 0) begin
            e_ncle = (m_op == 2'b00);
            e_nale = (m_op == 2'b01);
            e_oe   = (m_op != 2'b11);
            if (m_k > TS && m_k <= TS + TP) begin
                if (m_op == 2'b11) e_nre = 1'b0;
                else               e_nwe = 1'b0;
            end
        end
        return {e_nce, e_ncle, e_nale, e_nwe, e_nre, e_oe, e_dout,
                !e_busy && !reset, m_rsp_pulse, m_rsp_data, e_busy};
    endfunction

    function automatic logic [24:0] obs_vec();
        return {nce, ncle, nale, nwe, nre, nand_oe, nand_dout,
                req_ready, rsp_valid, rsp_data, busy};
    endfunction

    // Pad data is only meaningful while driven (or as the reset value).
    function automatic logic [24:0] mask_vec(input logic [24:0] ev);
        logic [24:0] m;
        m = '1;
        if (!ev[19] && m_used) m[18:11] = 8'h00;
        return m;
    endfunction

    task automatic drive_step();
        @(negedge clk);
        nand_din = 8'($urandom);
        if (q.size() > 0 && gap_left == 0) begin
            req_valid = 1'b1;
            req_op    = q[0].op;
            req_data  = q[0].data;
        end else begin
            req_valid = 1'b0;
            req_op    = 2'($urandom);
            req_data  = 8'($urandom);
            if (gap_left > 0) gap_left--;
        end
    endtask

    task automatic tick();
        bit old_rb2;
        @(posedge clk);
        m_acc = 0;
        if (reset) begin
            m_k = 0; m_wait = -1; m_idle = 0; m_used = 0; m_rsp_pulse = 0;
            m_rb1 = 0; m_rb2 = 0; m_op = 2'b00; m_data = 8'h00; m_rsp_data = 8'h00;
        end else begin
            old_rb2 = m_rb2;
            m_rsp_pulse = 0;
            if (m_k > 0) begin
                if (m_k == TS + TP && m_op == 2'b11) m_rsp_data = nand_din;
                if (m_k == N) begin
                    m_k = 0;
                    m_idle = 0;
                    if (m_op == 2'b11) m_rsp_pulse = 1;
`ifdef NAND_RB_WAIT_EN
                    if (m_op == 2'b00 && (m_data == 8'h10 || m_data == 8'h30 ||
                                          m_data == 8'hD0 || m_data == 8'hFF))
                        m_wait = 0;
`endif
                end else begin
                    m_k++;
                end
            end else if (m_wait >= 0) begin
                if (m_wait < 4) m_wait++;
                else if (old_rb2) begin
                    m_wait = -1;
                    m_idle = 0;
                end
            end else if (req_valid) begin
                m_k = 1; m_op = req_op; m_data = req_data;
                m_used = 1; m_acc = 1; m_idle = 0;
            end else begin
                m_idle++;
            end
            m_rb2 = m_rb1;
            m_rb1 = nand_rb;
        end
        if (m_acc) begin
            void'(q.pop_front());
            gap_left = (q.size() > 0) ? q[0].gap : 0;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        for (int i = 0; i < 6; i++) begin
            drive_step();
            if (i == 3) reset = 1'b0;
            #1;
            e = exp_vec(); o = obs_vec(); mk = mask_vec(e); compared++;
            if ((o & mk) !== (e & mk)) begin
                mismatched++;
                $display("FAIL reset cycle %0d: got %h want %h", i, o & mk, e & mk);
            end
            tick();
        end
    endtask

    task automatic test_cmd();
        q.push_back('{2'b00, 8'h90, 0});
        gap_left = 0;
        for (int i = 0; i < 9; i++) begin
            drive_step(); #1;
            e = exp_vec(); o = obs_vec(); mk = mask_vec(e); compared++;
            if ((o & mk) !== (e & mk)) begin
                mismatched++;
                $display("FAIL cmd cycle %0d: got %h want %h", i, o & mk, e & mk);
            end
            tick();
        end
    endtask

    task automatic test_read();
        q.push_back('{2'b11, 8'h00, 0});
        gap_left = 0;
        for (int i = 0; i < 9; i++) begin
            drive_step(); #1;
            e = exp_vec(); o = obs_vec(); mk = mask_vec(e); compared++;
            if ((o & mk) !== (e & mk)) begin
                mismatched++;
                $display("FAIL read cycle %0d: got %h want %h", i, o & mk, e & mk);
            end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        q.push_back('{2'b01, 8'h00, 0});
        q.push_back('{2'b11, 8'h00, 0});
        q.push_back('{2'b11, 8'h00, 0});
        gap_left = 0;
        for (int i = 0; i < 20; i++) begin
            drive_step(); #1;
            e = exp_vec(); o = obs_vec(); mk = mask_vec(e); compared++;
            if ((o & mk) !== (e & mk)) begin
                mismatched++;
                $display("FAIL b2b cycle %0d: got %h want %h", i, o & mk, e & mk);
            end
            tick();
        end
        compared++;
        if (q.size() != 0) begin
            mismatched++;
            $display("FAIL b2b_drain: %0d requests left, want 0", q.size());
        end
    endtask

    task automatic test_idle_timeout();
        for (int i = 0; i < 20; i++) begin
            drive_step(); #1;
            e = exp_vec(); o = obs_vec(); mk = mask_vec(e); compared++;
            if ((o & mk) !== (e & mk)) begin
                mismatched++;
                $display("FAIL idle cycle %0d: got %h want %h", i, o & mk, e & mk);
            end
            tick();
        end
        q.push_back('{2'b00, 8'hFF, 0});
        gap_left = 0;
        for (int i = 0; i < 12; i++) begin
            drive_step(); #1;
            e = exp_vec(); o = obs_vec(); mk = mask_vec(e); compared++;
            if ((o & mk) !== (e & mk)) begin
                mismatched++;
                $display("FAIL ce_reassert cycle %0d: got %h want %h", i, o & mk, e & mk);
            end
            tick();
        end
    endtask

    task automatic test_reset_mid_op();
        q.push_back('{2'b11, 8'h00, 0});
        gap_left = 0;
        for (int i = 0; i < 30 && m_k != TS + 1; i++) begin
            drive_step(); #1;
            e = exp_vec(); o = obs_vec(); mk = mask_vec(e); compared++;
            if ((o & mk) !== (e & mk)) begin
                mismatched++;
                $display("FAIL midrst_pre cycle %0d: got %h want %h", i, o & mk, e & mk);
            end
            tick();
        end
        if (m_k != TS + 1) begin
            compared++; mismatched++;
            $display("FAIL midrst_reach: READ never reached its strobe phase");
        end
        drive_step();
        reset = 1'b1;
        #1;
        e = exp_vec(); o = obs_vec(); mk = mask_vec(e); compared++;
        if ((o & mk) !== (e & mk)) begin
            mismatched++;
            $display("FAIL midrst_edge: got %h want %h", o & mk, e & mk);
        end
        tick();
        for (int i = 0; i < 8; i++) begin
            drive_step();
            reset = 1'b0;
            #1;
            e = exp_vec(); o = obs_vec(); mk = mask_vec(e); compared++;
            if ((o & mk) !== (e & mk)) begin
                mismatched++;
                $display("FAIL midrst_post cycle %0d: got %h want %h", i, o & mk, e & mk);
            end
            tick();
        end
    endtask

    task automatic test_random();
        int cyc;
        logic [7:0] cmd_bytes [4];
        cmd_bytes[0] = 8'h30; cmd_bytes[1] = 8'h00; cmd_bytes[2] = 8'h90; cmd_bytes[3] = 8'hFF;
        for (int i = 0; i < 50; i++) begin
            req_t r;
            r.op   = 2'($urandom);
            r.data = (r.op == 2'b00 && $urandom_range(0, 1) == 1)
                     ? cmd_bytes[$urandom_range(0, 3)] : 8'($urandom);
            r.gap  = ($urandom_range(0, 9) == 0) ? $urandom_range(14, 20) : $urandom_range(0, 2);
            q.push_back(r);
        end
        gap_left = q[0].gap;
        cyc = 0;
        while ((q.size() > 0 || m_k > 0 || m_wait >= 0) && cyc < 3000) begin
            drive_step(); #1;
            e = exp_vec(); o = obs_vec(); mk = mask_vec(e); compared++;
            if ((o & mk) !== (e & mk)) begin
                mismatched++;
                $display("FAIL random cycle %0d: got %h want %h", cyc, o & mk, e & mk);
            end
            tick();
            cyc++;
        end
        compared++;
        if (q.size() != 0 || m_k != 0) begin
            mismatched++;
            $display("FAIL random_drain: %0d requests left after %0d cycles, want 0", q.size(), cyc);
        end
    endtask

`ifdef NAND_RB_WAIT_EN
    task automatic test_rb_wait();
        nand_rb = 1'b0;
        q.push_back('{2'b00, 8'h30, 0});
        gap_left = 0;
        for (int i = 0; i < 130; i++) begin
            drive_step();
            if (i == 100) nand_rb = 1'b1;
            #1;
            e = exp_vec(); o = obs_vec(); mk = mask_vec(e); compared++;
            if ((o & mk) !== (e & mk)) begin
                mismatched++;
                $display("FAIL rb_wait cycle %0d: got %h want %h", i, o & mk, e & mk);
            end
            tick();
            if (i == 110) q.push_back('{2'b00, 8'h00, 0});
        end
    endtask
`endif

    initial begin
        test_reset();
        test_cmd();
        test_read();
        test_back_to_back();
        test_idle_timeout();
        test_reset_mid_op();
        test_random();
`ifdef NAND_RB_WAIT_EN
        test_rb_wait();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule

// File: doc/nand_bus_ctrl.md
Name: nand_bus_ctrl

Overview:
Sequences the raw 8-bit NAND flash bus (nce, ncle, nale, nwe, nre, bidirectional data through SB_IO with nand_oe, nand_dout and nand_din) on behalf of tst_6502's memory-mapped NAND port. Each accepted request runs one bus cycle: command latch, address latch, data write or data read. Programmable setup, pulse and hold timing is counted in clk cycles. Chip enable stays asserted across back-to-back requests and is released after an idle timeout.

Parameters:
T_SETUP, 2, cycles control/data are driven before the nwe/nre strobe falls (min 1)
T_PULSE, 2, cycles nwe/nre is held low (min 1)
T_HOLD, 1, cycles control/data are held after the strobe rises (min 1)
CE_IDLE, 16, idle cycles in IDLE before nce is deasserted (min 1)

Ports:
clk  in  1  system clock, single domain
reset  in  1  synchronous, active-high
req_valid  in  1  request present
req_op  in  2  00 CMD, 01 ADDR, 10 WRITE, 11 READ
req_data  in  8  byte for CMD/ADDR/WRITE; ignored for READ
req_ready  out  1  controller can accept a request this cycle
rsp_valid  out  1  one-cycle pulse: READ complete
rsp_data  out  8  byte captured by the last READ
busy  out  1  controller not in IDLE
nand_rb  in  1  NAND R/B# (low = busy); used only with the optional feature
nce  out  1  chip enable, active low
ncle  out  1  command latch enable
nale  out  1  address latch enable
nwe  out  1  write strobe, active low
nre  out  1  read strobe, active low
nand_oe  out  1  data pad output enable
nand_dout  out  8  data to pads
nand_din  in  8  data from pads

Behaviour:
- Reset values: nce=1, ncle=0, nale=0, nwe=1, nre=1, nand_oe=0, nand_dout=0, req_ready=0 while reset is high and 1 in the first cycle after, rsp_valid=0, rsp_data=0, busy=0, state=IDLE, all counters=0.
- States: IDLE, SETUP, PULSE, HOLD, plus WAIT_RB with the optional feature.
- Handshake: a request is accepted when req_valid && req_ready. req_ready=1 only in IDLE. While req_ready=0, req_valid is ignored and the requester holds the request. op and data are latched on acceptance.
- IDLE -> SETUP on acceptance.
  - SETUP: nce=0. ncle=1 for CMD, nale=1 for ADDR. For CMD/ADDR/WRITE, nand_oe=1 and nand_dout=latched byte. READ keeps nand_oe=0. Lasts T_SETUP cycles.
- PULSE: nwe=0 (CMD/ADDR/WRITE) or nre=0 (READ) for T_PULSE cycles. READ samples nand_din into rsp_data on the last PULSE cycle.
- HOLD: strobe back high. ncle, nale, nand_oe and nand_dout are unchanged. Lasts T_HOLD cycles, then -> IDLE.
- Timing: each op occupies T_SETUP+T_PULSE+T_HOLD cycles from the cycle after acceptance. req_ready rises in the first IDLE cycle, so back-to-back ops have exactly one idle cycle between them.
- On entering IDLE: ncle=0, nale=0, nand_oe=0. For READ, rsp_valid pulses in this first IDLE cycle. rsp_data holds until the next READ completes.
- nce stays 0 in IDLE. An idle counter counts IDLE cycles without acceptance and resets to 0 on acceptance. nce returns to 1 when the count reaches CE_IDLE. A later request re-asserts nce=0 in its first SETUP cycle.
- busy = (state != IDLE).
- Reset mid-op: all outputs return to reset values at that edge. A pending READ is lost and no rsp_valid is issued.

Optional Feature:
NAND_RB_WAIT_EN:
- Defined: after the HOLD of a CMD whose byte is 0x10, 0x30, 0xD0 or 0xFF, go to WAIT_RB instead of IDLE.
  - WAIT_RB first waits 4 fixed cycles (tWB), then until nand_rb=1 (synchronised through 2 flops).
  - During WAIT_RB: nce=0, req_ready=0, busy=1.
  - Exit to IDLE in the cycle after the synchronised nand_rb is seen high.
- Undefined: nand_rb is unused, WAIT_RB does not exist, and every op returns to IDLE.

Test Plan:
- Defaults; CMD 0x90 accepted at cycle 0 -> cycles 1-5 nce=0, ncle=1, nand_oe=1, nand_dout=0x90; nwe=0 exactly at cycles 3-4; req_ready=1 at cycle 6, ncle=0.
- READ accepted at cycle 0, nand_din=0xEC during cycles 3-4 -> nre=0 at cycles 3-4, nand_oe=0 throughout; rsp_valid=1 only at cycle 6 with rsp_data=0xEC.
- req_valid held high with ADDR 0x00 then two READs (din 0x98, 0xDA) -> each op 5 cycles plus 1 idle; nale=1 only during the ADDR; responses 0x98, 0xDA; nce never rises.
- After the last op, idle with req_valid=0 -> nce=0 for 15 idle cycles and nce=1 at the 16th; the next CMD 0xFF drives nce=0 at its first SETUP cycle.
- Reset asserted during PULSE of a READ -> next cycle nre=1, nce=1, nand_oe=0; rsp_valid never pulses; req_ready=1 the cycle after reset is released.
- NAND_RB_WAIT_EN, CMD 0x30, nand_rb held low 100 cycles then high -> req_ready stays 0 and busy stays 1 until 3 cycles after nand_rb rises; CMD 0x00 returns to IDLE normally.
